multicycle_muldiv: RTL and testbench
====================================

// Module: multicycle_muldiv
// PURPOSE
// - Iterative RV32M execution unit; consumer of the 5-bit alu_function code produced by ALU control for
//   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// - Sits beside the single-cycle ALU in the execute stage; multicycle core control stalls on busy.
// - Fixed latency for every accepted operation, so the stall logic is a simple counter.
// PARAMETERS
// - XLEN  32  operand/result width; iteration count = XLEN, counter width = $clog2(XLEN)+1
// PORTS
// - clock         in   1     single clock; all state updates on rising edge
// - reset_n       in   1     asynchronous, active-low reset
// - start         in   1     request; accepted only when busy==0
// - abort         in   1     cancel in-flight op (pipeline flush)
// - alu_function  in   5     `ALU_* code, sampled at accept
// - operand_a     in   XLEN  rs1 (multiplicand / dividend), sampled at accept
// - operand_b     in   XLEN  rs2 (multiplier / divisor), sampled at accept
// - busy          out  1     op in flight; start ignored while high
// - done          out  1     one-cycle pulse; result valid that cycle
// - result        out  XLEN  last completed result; held until next completion
// BEHAVIOUR
// - Reset (reset_n low, async): state=IDLE, busy=0, done=0, result=0, all datapath regs=0.
// - States: IDLE -> CALC -> FINISH -> IDLE.
// - IDLE: start=1 && abort=0 at edge k -> latch function, magnitudes, sign flags, special-case flags;
//   count=XLEN; enter CALC; busy=1 from edge k.
// - CALC: one radix-2 step per edge, edges k+1..k+XLEN; count decrements; count reaches 0 -> FINISH.
//   - Multiply: shift-add over 2*XLEN product register.
//   - Divide: restoring; remainder/quotient shift register.
// - FINISH (edge k+XLEN+1): apply sign fixup and special cases; write result; done=1 for exactly the
//   following cycle; busy=0 and state=IDLE in that same cycle.
// - Latency: done high in the cycle after edge k+XLEN+1 (cycle k+33 at XLEN=32) for every function code.
// - Back-to-back: start during the done cycle is accepted (busy already 0).
// - Signedness:
//   - MUL, MULH, DIV, REM: both operands signed.
//   - MULHSU: a signed, b unsigned.
//   - MULHU, DIVU, REMU: both unsigned.
//   - Datapath operates on magnitudes.
//   - Product negated if sign_a^sign_b.
//   - Quotient negated if sign_a^sign_b; remainder takes sign of a.
// - Result select:
//   - MUL = product[XLEN-1:0]; MULH* = product[2XLEN-1:XLEN].
//   - DIV* = quotient; REM* = remainder.
// - Special cases (flags latched at accept, override in FINISH, latency unchanged):
//   - divisor==0: DIV/DIVU -> all ones; REM/REMU -> operand_a.
//   - DIV overflow (a=-2^(XLEN-1), b=-1): DIV -> -2^(XLEN-1); REM -> 0.
// - Non-M code accepted: runs full latency, result=0 (`ALU_ZERO behaviour); never hangs.
// - abort=1 in any state: next edge -> IDLE, busy=0, no done, result unchanged.
//   abort+start in IDLE: abort wins, nothing accepted.
// - start while busy: ignored, no queueing; operand changes after accept have no effect.
// - reset_n low mid-operation: immediate return to reset values; no done.
// STRUCTURE
// - `ALU_MUL..`ALU_REMU codes and XLEN constants come from shared config.sv; unit adds none.
// - Shared package holds muldiv_state_t enum (IDLE/CALC/FINISH) for core-control visibility in debug.
// - One sub-module is natural: muldiv_sign_fixup.
//   - Combinational magnitude/negate/special-case result select.
//   - Used in FINISH; keeps iteration datapath purely unsigned.
// TESTING
// - MUL 7 x -3 -> result 0xFFFFFFEB; done exactly 33 cycles after accept; busy high 33 cycles.
// - MULH 0x80000000 x 0x80000000 -> 0x40000000.
//   MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//   MULHU same operands -> 0xFFFFFFFE.
// - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - Divide by 0: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
//   DIV 0x80000000/-1 -> 0x80000000; REM -> 0. All at full latency.
// - abort at cycle 10 of a DIV: no done, busy low next cycle, result keeps prior value.
//   reset_n pulse mid-MUL: all outputs 0.
// - Start held high through done: second op accepted in done cycle, completes 33 cycles later.
//   start while busy: no extra done pulse.

Source files
------------

// File: rtl/multicycle_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// datapath width, ALU function codes and the FSM state type that core
// control can observe when debugging stalls.
package multicycle_muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    localparam logic [4:0] ALU_ZERO   = 5'd0;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } muldiv_state_t;

    // True for the four codes that use the restoring divider
    function automatic logic is_div_op(input logic [4:0] f);
        return (f == ALU_DIV) || (f == ALU_DIVU) || (f == ALU_REM) || (f == ALU_REMU);
    endfunction

    // rs1 is treated as two's complement for these codes
    function automatic logic a_is_signed(input logic [4:0] f);
        return (f == ALU_MUL) || (f == ALU_MULH) || (f == ALU_MULHSU) ||
               (f == ALU_DIV) || (f == ALU_REM);
    endfunction

    // rs2 is treated as two's complement for these codes
    function automatic logic b_is_signed(input logic [4:0] f);
        return (f == ALU_MUL) || (f == ALU_MULH) || (f == ALU_DIV) || (f == ALU_REM);
    endfunction

endpackage

// File: rtl/multicycle_muldiv_sign_fixup.sv
// Combinational result stage: turns the unsigned magnitudes left by the
// iteration datapath into the architectural result, applying the sign
// correction and the divide-by-zero / signed-overflow overrides.
module multicycle_muldiv_sign_fixup
    import multicycle_muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic [4:0]      func,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic            neg_result,
    input  logic            sign_a,
    input  logic            div_zero,
    input  logic            div_ovf,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] product_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    // Signed product/quotient/remainder, then select by function code.
    // A zero divisor leaves the full dividend magnitude in the remainder,
    // so re-signing it with sign_a reproduces operand_a exactly.
    always_comb begin
        product   = {hi, lo};
        product_s = neg_result ? -product : product;
        quo_s     = neg_result ? -lo : lo;
        rem_s     = sign_a ? -hi : hi;
        result    = '0;
        case (func)
            ALU_MUL: begin
                result = product_s[XLEN-1:0];
            end
            ALU_MULH, ALU_MULHSU, ALU_MULHU: begin
                result = product_s[2*XLEN-1:XLEN];
            end
            ALU_DIV, ALU_DIVU: begin
                if (div_zero) begin
                    result = '1;
                end else if (div_ovf) begin
                    result = {1'b1, {(XLEN-1){1'b0}}};
                end else begin
                    result = quo_s;
                end
            end
            ALU_REM, ALU_REMU: begin
                if (div_ovf && !div_zero) begin
                    result = '0;
                end else begin
                    result = rem_s;
                end
            end
            default: begin
                result = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_muldiv.sv
// Iterative RV32M execution unit. Every accepted operation takes a fixed
// XLEN+1 edges after accept, so core control only needs a stall counter.
// The iteration datapath works purely on magnitudes; signs are restored
// by the fixup stage in FINISH.
module multicycle_muldiv
    import multicycle_muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [4:0]      alu_function,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_t state_q, state_next;

    logic [4:0]      func_q;
    logic            is_div_q;
    logic            sign_a_q;
    logic            neg_q;
    logic            div_zero_q;
    logic            div_ovf_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;
    logic [CNT_W-1:0] count_q;

    logic            accept;
    logic            finish_write;
    logic            in_sign_a;
    logic            in_sign_b;
    logic            in_is_div;
    logic [XLEN-1:0] in_mag_a;
    logic [XLEN-1:0] in_mag_b;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] hi_step;
    logic [XLEN-1:0] lo_step;
    logic [XLEN-1:0] fixup_result;

    assign busy = (state_q != IDLE);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic; abort beats everything, including a start in IDLE
    always_comb begin
        state_next   = state_q;
        accept       = 1'b0;
        finish_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_next = CALC;
                    accept     = 1'b1;
                end
            end
            CALC: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (count_q == CNT_W'(1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next   = IDLE;
                finish_write = !abort;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand decode at accept: sign flags, magnitudes and special cases
    always_comb begin
        in_is_div = is_div_op(alu_function);
        in_sign_a = a_is_signed(alu_function) && operand_a[XLEN-1];
        in_sign_b = b_is_signed(alu_function) && operand_b[XLEN-1];
        in_mag_a  = in_sign_a ? -operand_a : operand_a;
        in_mag_b  = in_sign_b ? -operand_b : operand_b;
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
        if (is_div_q) begin
            if (div_shift >= {1'b0, opnd_q}) begin
                hi_step = div_diff;
                lo_step = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_step = div_shift[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Datapath registers: latch at accept, iterate in CALC, publish in FINISH
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            func_q     <= '0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            count_q    <= '0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                func_q     <= alu_function;
                is_div_q   <= in_is_div;
                sign_a_q   <= in_sign_a;
                neg_q      <= in_sign_a ^ in_sign_b;
                div_zero_q <= (operand_b == '0);
                div_ovf_q  <= ((alu_function == ALU_DIV) || (alu_function == ALU_REM)) &&
                              (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
                hi_q       <= '0;
                lo_q       <= in_is_div ? in_mag_a : in_mag_b;
                opnd_q     <= in_is_div ? in_mag_b : in_mag_a;
                count_q    <= CNT_W'(XLEN);
            end else if ((state_q == CALC) && !abort) begin
                hi_q    <= hi_step;
                lo_q    <= lo_step;
                count_q <= count_q - CNT_W'(1);
            end else if (finish_write) begin
                result <= fixup_result;
                done   <= 1'b1;
            end
        end
    end

    multicycle_muldiv_sign_fixup #(
        .XLEN(XLEN)
    ) u_sign_fixup (
        .func      (func_q),
        .hi        (hi_q),
        .lo        (lo_q),
        .neg_result(neg_q),
        .sign_a    (sign_a_q),
        .div_zero  (div_zero_q),
        .div_ovf   (div_ovf_q),
        .result    (fixup_result)
    );

endmodule

// File: tb/tb_multicycle_muldiv.sv
// Self-checking bench for multicycle_muldiv: a table of directed vectors
// with hand-computed results and latency checks, followed by hand-written
// sequences for abort, reset, back-to-back and ignored-start behaviour.
module tb_multicycle_muldiv;
    import multicycle_muldiv_pkg::*;

    localparam int LATENCY = 33;
    localparam int TIMEOUT = 40;
    localparam int NVEC    = 22;

    typedef struct {
        string       name;
        logic [4:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [4:0]  alu_function;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int   n_vectors;
    int   n_miscompares;
    vec_t vecs[NVEC];

    multicycle_muldiv dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .alu_function(alu_function),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison: count it and report a miscompare with both values
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one request for a single edge; returns at the negedge after accept
    task automatic applyStimulus(input logic [4:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
        alu_function = f;
        operand_a    = a;
        operand_b    = b;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting cycles since accept and busy cycles
    task automatic waitDone(output int lat, output int busy_cycles, output bit seen);
        lat         = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        while (lat < TIMEOUT) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clock);
            lat++;
        end
    endtask

    // Watch a window of cycles and count done pulses
    task automatic countDones(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) pulses++;
            @(negedge clock);
        end
    endtask

    initial begin
        int lat;
        int bcyc;
        bit seen;
        int pulses;

        n_vectors     = 0;
        n_miscompares = 0;

        vecs[0]  = '{"MUL 7*-3",            ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{"MULH min*min",        ALU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{"MULHSU -1*ffffffff",  ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{"MULHU ffffffff^2",    ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4]  = '{"DIV -7/2",            ALU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{"REM -7/2",            ALU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{"DIVU 100/7",          ALU_DIVU,   32'd100,        32'd7,         32'd14};
        vecs[7]  = '{"REMU 100/7",          ALU_REMU,   32'd100,        32'd7,         32'd2};
        vecs[8]  = '{"DIV 5/0",             ALU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{"REMU 5/0",            ALU_REMU,   32'd5,          32'd0,         32'd5};
        vecs[10] = '{"DIV ovf",             ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{"REM ovf",             ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{"DIVU 5/0",            ALU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{"REM -5/0",            ALU_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
        vecs[14] = '{"DIV -5/0",            ALU_DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF};
        vecs[15] = '{"MUL 12345678*10",     ALU_MUL,    32'h1234_5678,  32'h10,        32'h2345_6780};
        vecs[16] = '{"MULHU 12345678*10",   ALU_MULHU,  32'h1234_5678,  32'h10,        32'h1};
        vecs[17] = '{"MULH -1*-1",          ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0};
        vecs[18] = '{"DIV -8/-3",           ALU_DIV,    32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'd2};
        vecs[19] = '{"REM 7/-2",            ALU_REM,    32'd7,          32'hFFFF_FFFE, 32'd1};
        vecs[20] = '{"DIVU ffffffff/1",     ALU_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF};
        vecs[21] = '{"non-M code",          ALU_ZERO,   32'd3,          32'd4,         32'd0};

        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        alu_function = '0;
        operand_a    = '0;
        operand_b    = '0;

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("reset busy",   {31'd0, busy},   32'd0);
        checkOutput("reset done",   {31'd0, done},   32'd0);
        checkOutput("reset result", result,          32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed vector table: result, latency and busy duration
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].func, vecs[i].a, vecs[i].b);
            waitDone(lat, bcyc, seen);
            checkOutput({vecs[i].name, " done seen"}, {31'd0, seen}, 32'd1);
            checkOutput({vecs[i].name, " result"},    result,        vecs[i].expected);
            checkOutput({vecs[i].name, " latency"},   32'(lat),      32'(LATENCY));
            checkOutput({vecs[i].name, " busy cyc"},  32'(bcyc),     32'(LATENCY));
            checkOutput({vecs[i].name, " busy@done"}, {31'd0, busy}, 32'd0);
            @(negedge clock);
            checkOutput({vecs[i].name, " done width"}, {31'd0, done}, 32'd0);
        end

        // Abort during a DIV: no done, busy drops, prior result kept
        applyStimulus(ALU_DIVU, 32'd100, 32'd7);
        waitDone(lat, bcyc, seen);
        checkOutput("abort setup result", result, 32'd14);
        @(negedge clock);
        applyStimulus(ALU_DIV, 32'd100, 32'd3);
        repeat (10) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        countDones(TIMEOUT, pulses);
        checkOutput("abort done pulses", 32'(pulses), 32'd0);
        checkOutput("abort result kept", result, 32'd14);

        // Abort together with start in IDLE: nothing accepted
        alu_function = ALU_MUL;
        operand_a    = 32'd2;
        operand_b    = 32'd2;
        start        = 1'b1;
        abort        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort+start busy", {31'd0, busy}, 32'd0);
        countDones(TIMEOUT, pulses);
        checkOutput("abort+start dones", 32'(pulses), 32'd0);

        // Reset pulse in the middle of a MUL
        applyStimulus(ALU_MUL, 32'd3, 32'd5);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset busy",   {31'd0, busy}, 32'd0);
        checkOutput("midreset done",   {31'd0, done}, 32'd0);
        checkOutput("midreset result", result,        32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        countDones(TIMEOUT, pulses);
        checkOutput("midreset dones", 32'(pulses), 32'd0);

        // Start held through done: second op accepted in the done cycle;
        // operand changes while busy must not disturb the first op
        alu_function = ALU_MUL;
        operand_a    = 32'd6;
        operand_b    = 32'd7;
        start        = 1'b1;
        @(negedge clock);
        operand_a = 32'd9;
        operand_b = 32'd9;
        waitDone(lat, bcyc, seen);
        checkOutput("b2b first result",  result,     32'd42);
        checkOutput("b2b first latency", 32'(lat),   32'(LATENCY));
        @(negedge clock);
        start = 1'b0;
        checkOutput("b2b second busy", {31'd0, busy}, 32'd1);
        checkOutput("b2b done width",  {31'd0, done}, 32'd0);
        waitDone(lat, bcyc, seen);
        checkOutput("b2b second result",  result,   32'd81);
        checkOutput("b2b second latency", 32'(lat), 32'(LATENCY));
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
